// File: rtl/uart_host_pkg.sv
// Shared definitions for the RAM loader host: opcodes, status code and FSM states.
// Used by uart_host and uart_host_word; optional response timeout is enabled by UART_HOST_TIMEOUT_EN.
package uart_host_pkg;

   localparam logic [7:0] OP_IRAM_WR  = 8'h01;
   localparam logic [7:0] OP_IRAM_RD  = 8'h02;
   localparam logic [7:0] OP_DRAM_WR  = 8'h03;
   localparam logic [7:0] OP_DRAM_RD  = 8'h04;
   localparam logic [7:0] OP_CPU_RUN  = 8'h05;
   localparam logic [7:0] OP_CPU_HALT = 8'h06;

   localparam logic [7:0] STATUS_OK = 8'h00;

   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE,
      SEND_OP,
      SEND_ADDR,
      SEND_LEN,
      SEND_DATA,
      RECV_DATA,
      RECV_ACK
   } state_e;

   function automatic logic op_is_valid(input logic [7:0] op);
      return (op >= OP_IRAM_WR) && (op <= OP_CPU_HALT);
   endfunction

   // Run/halt carry no address, length or payload.
   function automatic logic op_is_ctrl(input logic [7:0] op);
      return (op == OP_CPU_RUN) || (op == OP_CPU_HALT);
   endfunction

   function automatic logic op_is_write(input logic [7:0] op);
      return (op == OP_IRAM_WR) || (op == OP_DRAM_WR);
   endfunction

endpackage

// File: rtl/uart_host_word.sv
// Four-byte word serializer/deserializer: load a word and shift bytes out LSB first,
// or pack received bytes LSB first into a word.
module uart_host_word
   import uart_host_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            clr_i,
   input  logic            load_i,
   input  logic [XLEN-1:0] load_data_i,
   input  logic            shift_i,
   input  logic            pack_i,
   input  logic [7:0]      pack_byte_i,
   output logic [7:0]      byte_o,
   output logic [XLEN-1:0] word_o,
   output logic            empty_o,
   output logic            shift_last_o,
   output logic            pack_last_o
);

   localparam logic [2:0] FULL_CNT = 3'(WORD_BYTES);

   logic [XLEN-1:0] data_q, data_d;
   logic [2:0]      cnt_q, cnt_d;

   // cnt counts bytes still to send when shifting, bytes collected when packing.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         cnt_d = 3'd0;
      end else if (load_i) begin
         data_d = load_data_i;
         cnt_d  = FULL_CNT;
      end else if (shift_i) begin
         data_d = {8'h00, data_q[XLEN-1:8]};
         cnt_d  = cnt_q - 3'd1;
      end else if (pack_i) begin
         data_d = {pack_byte_i, data_q[XLEN-1:8]};
         cnt_d  = (cnt_q == FULL_CNT - 3'd1) ? 3'd0 : cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         data_q <= '0;
         cnt_q  <= 3'd0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign byte_o       = data_q[7:0];
   assign word_o       = data_q;
   assign empty_o      = (cnt_q == 3'd0);
   assign shift_last_o = (cnt_q == 3'd1);
   assign pack_last_o  = (cnt_q == FULL_CNT - 3'd1);

endmodule

// File: rtl/uart_host.sv
// Host-side initiator of the RAM loader byte protocol (op, addr, len, payload, status).
// Define UART_HOST_TIMEOUT_EN to bound the wait for responder bytes by TIMEOUT_CYC cycles.
module uart_host
   import uart_host_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic [7:0]      cmd_op_i,
   input  logic [XLEN-1:0] cmd_addr_i,
   input  logic [XLEN-1:0] cmd_len_i,
   input  logic            cmd_vld_i,
   output logic            cmd_rdy_o,
   input  logic [XLEN-1:0] wr_data_i,
   input  logic            wr_data_vld_i,
   output logic            wr_data_rdy_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic            rd_data_vld_o,
   output logic [7:0]      uart_tx_data_o,
   output logic            uart_tx_data_vld_o,
   input  logic            uart_tx_data_rdy_i,
   input  logic [7:0]      uart_rx_data_i,
   input  logic            uart_rx_data_vld_i,
   output logic            uart_rx_data_rdy_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o
);

   localparam logic [XLEN-1:0] ONE = XLEN'(1);

   state_e          state_q, state_d;
   logic [7:0]      op_q, op_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] len_q, len_d;
   logic [XLEN-1:0] word_cnt_q, word_cnt_d;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            rd_vld_q, rd_vld_d;

   logic            cmd_rdy, wr_rdy, tx_vld, rx_rdy;
   logic [7:0]      tx_data;

   logic            w_clr, w_load, w_shift, w_pack;
   logic [7:0]      w_byte;
   logic [XLEN-1:0] w_word;
   logic            w_empty, w_shift_last, w_pack_last;

   logic [7:0]      addr_byte [0:WORD_BYTES-1];
   logic [7:0]      len_byte  [0:WORD_BYTES-1];

   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_field_bytes
      assign addr_byte[gi] = addr_q[gi*8 +: 8];
      assign len_byte[gi]  = len_q[gi*8 +: 8];
   end

`ifdef UART_HOST_TIMEOUT_EN
   logic [31:0] tmo_cnt_q, tmo_cnt_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      done_d     = 1'b0;
      err_d      = err_q;
      rd_vld_d   = 1'b0;
      w_clr      = 1'b0;
      w_load     = 1'b0;
      w_shift    = 1'b0;
      w_pack     = 1'b0;
      cmd_rdy    = 1'b0;
      wr_rdy     = 1'b0;
      tx_vld     = 1'b0;
      tx_data    = 8'h00;
      rx_rdy     = 1'b0;
`ifdef UART_HOST_TIMEOUT_EN
      tmo_cnt_d  = 32'd0;
`endif

      case (state_q)
         IDLE: begin
            cmd_rdy = 1'b1;
            if (cmd_vld_i) begin
               op_d       = cmd_op_i;
               addr_d     = cmd_addr_i;
               len_d      = cmd_len_i;
               word_cnt_d = cmd_len_i;
               byte_idx_d = 2'd0;
               err_d      = 1'b0;
               w_clr      = 1'b1;
               state_d    = SEND_OP;
            end
         end
         SEND_OP: begin
            // Unknown opcodes are rejected here so nothing reaches the wire.
            if (!op_is_valid(op_q)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tx_vld  = 1'b1;
               tx_data = op_q;
               if (uart_tx_data_rdy_i) begin
                  if (op_is_ctrl(op_q)) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = SEND_ADDR;
                  end
               end
            end
         end
         SEND_ADDR: begin
            tx_vld  = 1'b1;
            tx_data = addr_byte[byte_idx_q];
            if (uart_tx_data_rdy_i) begin
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_d = SEND_LEN;
               end
            end
         end
         SEND_LEN: begin
            tx_vld  = 1'b1;
            tx_data = len_byte[byte_idx_q];
            if (uart_tx_data_rdy_i) begin
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  if (len_q == '0)            state_d = RECV_ACK;
                  else if (op_is_write(op_q)) state_d = SEND_DATA;
                  else                        state_d = RECV_DATA;
               end
            end
         end
         SEND_DATA: begin
            if (w_empty) begin
               wr_rdy = wr_data_vld_i;
               w_load = wr_data_vld_i;
            end else begin
               tx_vld  = 1'b1;
               tx_data = w_byte;
               if (uart_tx_data_rdy_i) begin
                  w_shift = 1'b1;
                  if (w_shift_last) begin
                     word_cnt_d = word_cnt_q - ONE;
                     if (word_cnt_q == ONE) state_d = RECV_ACK;
                  end
               end
            end
         end
         RECV_DATA: begin
            rx_rdy = 1'b1;
            if (uart_rx_data_vld_i) begin
               w_pack = 1'b1;
               if (w_pack_last) begin
                  rd_vld_d   = 1'b1;
                  word_cnt_d = word_cnt_q - ONE;
                  if (word_cnt_q == ONE) state_d = RECV_ACK;
               end
            end
         end
         RECV_ACK: begin
            rx_rdy = 1'b1;
            if (uart_rx_data_vld_i) begin
               done_d  = 1'b1;
               state_d = IDLE;
               if (uart_rx_data_i != STATUS_OK) err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef UART_HOST_TIMEOUT_EN
      // Counts consecutive idle cycles while waiting on the responder.
      if ((state_q == RECV_DATA || state_q == RECV_ACK) && !uart_rx_data_vld_i) begin
         if (tmo_cnt_q == TIMEOUT_CYC - 32'd1) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         op_q       <= 8'h00;
         addr_q     <= '0;
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_idx_q <= 2'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rd_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_idx_q <= byte_idx_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rd_vld_q   <= rd_vld_d;
      end
   end

`ifdef UART_HOST_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) tmo_cnt_q <= 32'd0;
      else          tmo_cnt_q <= tmo_cnt_d;
   end
`endif

   uart_host_word #(
      .XLEN (XLEN)
   ) u_word (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .clr_i        (w_clr),
      .load_i       (w_load),
      .load_data_i  (wr_data_i),
      .shift_i      (w_shift),
      .pack_i       (w_pack),
      .pack_byte_i  (uart_rx_data_i),
      .byte_o       (w_byte),
      .word_o       (w_word),
      .empty_o      (w_empty),
      .shift_last_o (w_shift_last),
      .pack_last_o  (w_pack_last)
   );

   assign cmd_rdy_o          = cmd_rdy;
   assign wr_data_rdy_o      = wr_rdy;
   assign rd_data_o          = w_word;
   assign rd_data_vld_o      = rd_vld_q;
   assign uart_tx_data_o     = tx_data;
   assign uart_tx_data_vld_o = tx_vld;
   assign uart_rx_data_rdy_o = rx_rdy;
   // busy covers the done cycle, which is spent back in IDLE.
   assign busy_o             = (state_q != IDLE) || done_q;
   assign done_o             = done_q;
   assign err_o              = err_q;

endmodule

// File: tb/tb_uart_host.sv
// Scoreboard bench for uart_host: expected tx bytes and read words are queued with the
// stimulus and checked as the DUT emits them; timeout scenario runs with UART_HOST_TIMEOUT_EN.
module tb_uart_host;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  cmd_op;
   logic [31:0] cmd_addr, cmd_len;
   logic        cmd_vld;
   logic        cmd_rdy_o;
   logic [31:0] wr_data;
   logic        wr_vld;
   logic        wr_rdy_o;
   logic [31:0] rd_data_o;
   logic        rd_vld_o;
   logic [7:0]  tx_data_o;
   logic        tx_vld_o;
   logic        tx_rdy;
   logic [7:0]  rx_data;
   logic        rx_vld;
   logic        rx_rdy_o;
   logic        busy_o, done_o, err_o;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0]  exp_tx_q [$];
   logic [31:0] exp_rd_q [$];
   logic [7:0]  rx_feed_q [$];
   logic [31:0] wr_feed_q [$];

   int  tx_count = 0;
   int  tx_limit = 1_000_000;
   int  tx_mode  = 0;
   bit  rx_hs_seen = 1'b0;
   bit  wr_hs_seen = 1'b0;
   bit  prev_rx_hs = 1'b0;

   always #5 clk = ~clk;

   uart_host #(
      .XLEN        (32),
      .TIMEOUT_CYC (32'd100)
   ) dut (
      .clk_i              (clk),
      .rst_n_i            (rst_n),
      .cmd_op_i           (cmd_op),
      .cmd_addr_i         (cmd_addr),
      .cmd_len_i          (cmd_len),
      .cmd_vld_i          (cmd_vld),
      .cmd_rdy_o          (cmd_rdy_o),
      .wr_data_i          (wr_data),
      .wr_data_vld_i      (wr_vld),
      .wr_data_rdy_o      (wr_rdy_o),
      .rd_data_o          (rd_data_o),
      .rd_data_vld_o      (rd_vld_o),
      .uart_tx_data_o     (tx_data_o),
      .uart_tx_data_vld_o (tx_vld_o),
      .uart_tx_data_rdy_i (tx_rdy),
      .uart_rx_data_i     (rx_data),
      .uart_rx_data_vld_i (rx_vld),
      .uart_rx_data_rdy_o (rx_rdy_o),
      .busy_o             (busy_o),
      .done_o             (done_o),
      .err_o              (err_o)
   );

   // Monitor: handshakes are judged at the falling edge, taking effect at the next rising edge.
   initial begin
      logic [7:0]  eb;
      logic [31:0] ew;
      bit          cur_rx_hs;
      forever begin
         @(negedge clk);
         cur_rx_hs  = rst_n && rx_vld && rx_rdy_o;
         wr_hs_seen = rst_n && wr_vld && wr_rdy_o;
         if (rst_n && tx_vld_o && tx_rdy) begin
            tx_count++;
            vectors++;
            if (exp_tx_q.size() == 0) begin
               miscompares++;
               $display("FAIL tx_byte unexpected byte %02h, none expected", tx_data_o);
            end else begin
               eb = exp_tx_q.pop_front();
               if (tx_data_o !== eb) begin
                  miscompares++;
                  $display("FAIL tx_byte got %02h want %02h", tx_data_o, eb);
               end
            end
         end
         if (rst_n && rd_vld_o) begin
            vectors++;
            if (exp_rd_q.size() == 0) begin
               miscompares++;
               $display("FAIL rd_word unexpected word %08h", rd_data_o);
            end else begin
               ew = exp_rd_q.pop_front();
               if (rd_data_o !== ew) begin
                  miscompares++;
                  $display("FAIL rd_word got %08h want %08h", rd_data_o, ew);
               end
            end
            vectors++;
            if (prev_rx_hs !== 1'b1) begin
               miscompares++;
               $display("FAIL rd_timing rd_vld without rx handshake one cycle earlier got %0b want 1", prev_rx_hs);
            end
         end
         prev_rx_hs = cur_rx_hs;
         rx_hs_seen = cur_rx_hs;
      end
   end

   // Responder model: drives tx ready, rx bytes and write words just after each rising edge.
   initial begin
      bit phase;
      phase   = 1'b0;
      tx_rdy  = 1'b0;
      rx_vld  = 1'b0;
      rx_data = 8'h00;
      wr_vld  = 1'b0;
      wr_data = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (rx_hs_seen && rx_feed_q.size() > 0) rx_feed_q.delete(0);
         if (wr_hs_seen && wr_feed_q.size() > 0) wr_feed_q.delete(0);
         rx_hs_seen = 1'b0;
         wr_hs_seen = 1'b0;
         rx_vld  = (rx_feed_q.size() > 0);
         rx_data = (rx_feed_q.size() > 0) ? rx_feed_q[0] : 8'h00;
         wr_vld  = (wr_feed_q.size() > 0);
         wr_data = (wr_feed_q.size() > 0) ? wr_feed_q[0] : 32'h0;
         phase   = ~phase;
         tx_rdy  = (tx_mode == 1) ? phase : 1'b1;
         if (tx_count >= tx_limit) tx_rdy = 1'b0;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation did not finish, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] len,
                           output bit ok);
      @(posedge clk);
      #1;
      cmd_op   = op;
      cmd_addr = addr;
      cmd_len  = len;
      cmd_vld  = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_rdy_o) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      cmd_vld  = 1'b0;
      cmd_op   = 8'hA5;
      cmd_addr = $urandom;
      cmd_len  = $urandom;
   endtask

   task automatic wait_done(input int max_cyc, output bit seen, output logic err_v,
                            output logic busy_v, output int cyc);
      seen = 1'b0; err_v = 1'b0; busy_v = 1'b0; cyc = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         cyc++;
         if (done_o) begin
            seen = 1'b1; err_v = err_o; busy_v = busy_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({cmd_rdy_o, wr_rdy_o, rd_vld_o, tx_vld_o, rx_rdy_o, busy_o, done_o, err_o} !== 8'b1000_0000) begin
         miscompares++;
         $display("FAIL reset_ctrl got %08b want 10000000",
                  {cmd_rdy_o, wr_rdy_o, rd_vld_o, tx_vld_o, rx_rdy_o, busy_o, done_o, err_o});
      end
      vectors++;
      if ({rd_data_o, tx_data_o} !== 40'h0) begin
         miscompares++;
         $display("FAIL reset_data got %010h want 0", {rd_data_o, tx_data_o});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      $display("[tb] reset checked");
   endtask

   task automatic test_iram_write();
      logic [7:0] b [13];
      bit ok, seen; logic e, bz; int cyc;
      b = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
      foreach (b[i]) exp_tx_q.push_back(b[i]);
      wr_feed_q.push_back(32'hDEADBEEF);
      rx_feed_q.push_back(8'h00);
      send_cmd(8'h01, 32'h0000_0010, 32'd1, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL iram_accept got 0 want 1"); end
      @(negedge clk);
      vectors++;
      if (busy_o !== 1'b1) begin miscompares++; $display("FAIL iram_busy got %0b want 1", busy_o); end
      wait_done(200, seen, e, bz, cyc);
      vectors++;
      if ({seen, e, bz} !== 3'b101) begin
         miscompares++;
         $display("FAIL iram_done got seen/err/busy %03b want 101", {seen, e, bz});
      end
      @(negedge clk);
      vectors++;
      if ({busy_o, done_o, exp_tx_q.size() == 0} !== 3'b001) begin
         miscompares++;
         $display("FAIL iram_end got busy/done/txq_empty %03b want 001", {busy_o, done_o, exp_tx_q.size() == 0});
      end
      $display("[tb] iram write op=01 addr=00000010 len=1 data=deadbeef");
   endtask

   task automatic test_dram_read();
      logic [7:0] b [9];
      logic [7:0] r [9];
      bit ok, seen; logic e, bz; int cyc;
      b = '{8'h04, 8'h78, 8'h56, 8'h34, 8'h12, 8'h02, 8'h00, 8'h00, 8'h00};
      r = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
      foreach (b[i]) exp_tx_q.push_back(b[i]);
      foreach (r[i]) rx_feed_q.push_back(r[i]);
      exp_rd_q.push_back(32'h44332211);
      exp_rd_q.push_back(32'h88776655);
      send_cmd(8'h04, 32'h1234_5678, 32'd2, ok);
      wait_done(200, seen, e, bz, cyc);
      vectors++;
      if ({ok, seen, e} !== 3'b110) begin
         miscompares++;
         $display("FAIL dram_done got ok/seen/err %03b want 110", {ok, seen, e});
      end
      vectors++;
      if ((exp_rd_q.size() + exp_tx_q.size() + rx_feed_q.size()) != 0) begin
         miscompares++;
         $display("FAIL dram_left got %0d rd %0d tx %0d rx left want 0", exp_rd_q.size(),
                  exp_tx_q.size(), rx_feed_q.size());
      end
      $display("[tb] dram read op=04 len=2 words=44332211,88776655");
   endtask

   task automatic test_run_toggle();
      bit ok, seen; logic e, bz; int cyc;
      tx_mode = 1;
      exp_tx_q.push_back(8'h05);
      send_cmd(8'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ok);
      wait_done(50, seen, e, bz, cyc);
      vectors++;
      if ({ok, seen, e, bz} !== 4'b1101) begin
         miscompares++;
         $display("FAIL run_done got ok/seen/err/busy %04b want 1101", {ok, seen, e, bz});
      end
      @(negedge clk);
      vectors++;
      if ({busy_o, done_o, exp_tx_q.size() == 0} !== 3'b001) begin
         miscompares++;
         $display("FAIL run_end got busy/done/txq_empty %03b want 001", {busy_o, done_o, exp_tx_q.size() == 0});
      end
      tx_mode = 0;
      $display("[tb] cpu run op=05 with toggling tx ready");
   endtask

   task automatic test_status_err();
      logic [7:0] b [9];
      bit ok, seen; logic e, bz; int cyc;
      b = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      foreach (b[i]) exp_tx_q.push_back(b[i]);
      rx_feed_q.push_back(8'hA1); rx_feed_q.push_back(8'hB2);
      rx_feed_q.push_back(8'hC3); rx_feed_q.push_back(8'hD4);
      rx_feed_q.push_back(8'h01);
      exp_rd_q.push_back(32'hD4C3B2A1);
      send_cmd(8'h02, 32'h0000_0100, 32'd1, ok);
      wait_done(200, seen, e, bz, cyc);
      vectors++;
      if ({ok, seen, e} !== 3'b111) begin
         miscompares++;
         $display("FAIL status_err got ok/seen/err %03b want 111", {ok, seen, e});
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %0b want 1", err_o); end
      exp_tx_q.push_back(8'h06);
      send_cmd(8'h06, 32'h0, 32'h0, ok);
      @(negedge clk);
      vectors++;
      if ({ok, err_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL err_clear got ok/err %02b want 10", {ok, err_o});
      end
      wait_done(50, seen, e, bz, cyc);
      vectors++;
      if ({seen, e} !== 2'b10) begin
         miscompares++;
         $display("FAIL halt_done got seen/err %02b want 10", {seen, e});
      end
      $display("[tb] iram read with status 01 then cpu halt op=06");
   endtask

   task automatic test_bad_op();
      bit ok, seen; logic e, bz; int cyc;
      send_cmd(8'h07, 32'h0, 32'd1, ok);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({ok, err_o, busy_o} !== 3'b110) begin
         miscompares++;
         $display("FAIL bad_op got ok/err/busy %03b want 110", {ok, err_o, busy_o});
      end
      wait_done(10, seen, e, bz, cyc);
      vectors++;
      if (seen !== 1'b0) begin miscompares++; $display("FAIL bad_op_done got %0b want 0", seen); end
      $display("[tb] illegal op=07 rejected");
   endtask

   task automatic test_zero_len();
      logic [7:0] b [9];
      bit ok, seen; logic e, bz; int cyc;
      b = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
      foreach (b[i]) exp_tx_q.push_back(b[i]);
      rx_feed_q.push_back(8'h00);
      send_cmd(8'h03, 32'h8000_0000, 32'd0, ok);
      wait_done(100, seen, e, bz, cyc);
      vectors++;
      if ({ok, seen, e, exp_tx_q.size() == 0} !== 4'b1101) begin
         miscompares++;
         $display("FAIL zero_len got ok/seen/err/txq_empty %04b want 1101", {ok, seen, e, exp_tx_q.size() == 0});
      end
      $display("[tb] dram write op=03 len=0");
   endtask

   task automatic test_back_to_back();
      logic [7:0] b [17];
      bit ok, seen; logic e, bz; int cyc;
      tx_mode = 1;
      b = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h20, 8'h02, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      foreach (b[i]) exp_tx_q.push_back(b[i]);
      wr_feed_q.push_back(32'h03020100);
      wr_feed_q.push_back(32'h07060504);
      rx_feed_q.push_back(8'h00);
      send_cmd(8'h01, 32'h2000_0004, 32'd2, ok);
      wait_done(300, seen, e, bz, cyc);
      vectors++;
      if ({ok, seen, e, exp_tx_q.size() == 0, wr_feed_q.size() == 0} !== 5'b11011) begin
         miscompares++;
         $display("FAIL b2b got ok/seen/err/txq_empty/wrq_empty %05b want 11011",
                  {ok, seen, e, exp_tx_q.size() == 0, wr_feed_q.size() == 0});
      end
      tx_mode = 0;
      $display("[tb] iram write op=01 len=2 back-to-back words, toggling tx ready");
   endtask

   task automatic test_reset_mid();
      logic [7:0] b [13];
      bit ok, hit; int base, vld_seen;
      b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'h0D, 8'hF0, 8'hFE, 8'hCA};
      foreach (b[i]) exp_tx_q.push_back(b[i]);
      wr_feed_q.push_back(32'hCAFEF00D);
      base = tx_count;
      tx_limit = base + 12;
      send_cmd(8'h01, 32'h0, 32'd1, ok);
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (tx_count == base + 12) begin hit = 1'b1; break; end
      end
      vectors++;
      if ({ok, hit} !== 2'b11) begin
         miscompares++;
         $display("FAIL mid_progress got ok/reached %02b want 11", {ok, hit});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({cmd_rdy_o, wr_rdy_o, rd_vld_o, tx_vld_o, rx_rdy_o, busy_o, done_o, err_o} !== 8'b1000_0000) begin
         miscompares++;
         $display("FAIL mid_reset_ctrl got %08b want 10000000",
                  {cmd_rdy_o, wr_rdy_o, rd_vld_o, tx_vld_o, rx_rdy_o, busy_o, done_o, err_o});
      end
      vectors++;
      if ({rd_data_o, tx_data_o} !== 40'h0) begin
         miscompares++;
         $display("FAIL mid_reset_data got %010h want 0", {rd_data_o, tx_data_o});
      end
      vectors++;
      if (exp_tx_q.size() != 1) begin
         miscompares++;
         $display("FAIL mid_unsent got %0d bytes left want 1", exp_tx_q.size());
      end
      exp_tx_q.delete();
      tx_limit = 1_000_000;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      vld_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (tx_vld_o) vld_seen++;
      end
      vectors++;
      if (vld_seen != 0) begin
         miscompares++;
         $display("FAIL mid_quiet got %0d tx valid cycles want 0", vld_seen);
      end
      $display("[tb] reset after third payload byte");
   endtask

`ifdef UART_HOST_TIMEOUT_EN
   task automatic test_timeout();
      logic [7:0] b [9];
      bit ok, hit, seen; logic e, bz; int base, cyc;
      b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      foreach (b[i]) exp_tx_q.push_back(b[i]);
      base = tx_count;
      send_cmd(8'h02, 32'h0, 32'd1, ok);
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (tx_count == base + 9) begin hit = 1'b1; break; end
      end
      wait_done(300, seen, e, bz, cyc);
      vectors++;
      if ({ok, hit, seen, e} !== 4'b1111) begin
         miscompares++;
         $display("FAIL timeout_done got ok/hdr/seen/err %04b want 1111", {ok, hit, seen, e});
      end
      vectors++;
      if (cyc - 1 != 100) begin
         miscompares++;
         $display("FAIL timeout_cycle got %0d want 100", cyc - 1);
      end
      $display("[tb] iram read op=02 with silent responder timed out");
   endtask
`endif

   initial begin
      rst_n    = 1'b0;
      cmd_op   = 8'h00;
      cmd_addr = 32'h0;
      cmd_len  = 32'h0;
      cmd_vld  = 1'b0;
      test_reset();
      test_iram_write();
      test_dram_read();
      test_run_toggle();
      test_status_err();
      test_bad_op();
      test_zero_len();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_HOST_TIMEOUT_EN
      test_timeout();
`endif
      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_host.md
UART_HOST -- requirements
Module: uart_host

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address word width; only 32 is supported.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 32'd1_000_000, meaning response-wait limit in clk_i cycles (used only with UART_HOST_TIMEOUT_EN).
REQ-003 SHALL have ports (one clock; reset synchronous, active-low):
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous active-low reset
- cmd_op_i  in  8  opcode
- cmd_addr_i  in  XLEN  byte address
- cmd_len_i  in  XLEN  word count
- cmd_vld_i  in  1  command valid
- cmd_rdy_o  out  1  command accepted
- wr_data_i  in  XLEN  write word
- wr_data_vld_i  in  1  write word valid
- wr_data_rdy_o  out  1  write word taken
- rd_data_o  out  XLEN  read word
- rd_data_vld_o  out  1  read word valid, one-cycle pulse
- uart_tx_data_o  out  8  byte to transmitter
- uart_tx_data_vld_o  out  1  byte valid
- uart_tx_data_rdy_i  in  1  transmitter ready
- uart_rx_data_i  in  8  byte from receiver
- uart_rx_data_vld_i  in  1  receiver byte valid
- uart_rx_data_rdy_o  out  1  byte consumed
- busy_o  out  1  transaction in progress
- done_o  out  1  transaction complete, one-cycle pulse
- err_o  out  1  sticky error, cleared on next accepted command

Function
REQ-004 SHALL act as host-side initiator of the RAM loader byte protocol: op byte, 4 addr bytes, 4 len bytes, payload, then one status byte from the responder.
REQ-005 SHALL support opcodes 0x01 IRAM write, 0x02 IRAM read, 0x03 DRAM write, 0x04 DRAM read, 0x05 CPU run, 0x06 CPU halt; 0x05/0x06 send op byte only.
REQ-006 SHALL raise err_o, return to IDLE, and send nothing on any other opcode.
REQ-007 SHALL transfer a byte only in a cycle with vld and rdy both high, on every handshake.
REQ-008 SHALL send all multi-byte fields and data words LSB byte first.
REQ-009 SHALL use states IDLE, SEND_OP, SEND_ADDR, SEND_LEN, SEND_DATA, RECV_DATA, RECV_ACK.
REQ-010 SHALL assert cmd_rdy_o only in IDLE, and SHALL leave IDLE the cycle after cmd_vld_i && cmd_rdy_o.
REQ-011 SHALL register op, addr and len on command accept; later input changes SHALL have no effect.
REQ-012 SHALL pulse wr_data_rdy_o for one cycle in SEND_DATA when wr_data_vld_i is high and the 4-byte shift buffer is empty, then send the buffered word's 4 bytes.
REQ-013 SHALL pack 4 received bytes per word in RECV_DATA and pulse rd_data_vld_o for one cycle, 1 cycle after the 4th byte handshake.
REQ-014 SHALL skip SEND_DATA/RECV_DATA when len is 0.
REQ-015 SHALL use a 32-bit word counter with no wrap; len 0xFFFF_FFFF SHALL be legal.
REQ-016 SHALL hold uart_rx_data_rdy_o high only in RECV_DATA and RECV_ACK.
REQ-017 SHALL accept status byte 0x00 as success and pulse done_o.
REQ-018 SHALL treat a nonzero status byte as failure: set err_o and pulse done_o.
REQ-019 SHALL pulse done_o one cycle after the final handshake for 0x05/0x06.
REQ-020 SHALL hold busy_o high from the cycle after command accept through the done_o cycle.

Reset
REQ-021 SHALL, with rst_n_i low at a clk_i edge, enter IDLE with all outputs 0 except cmd_rdy_o=1.
REQ-022 SHALL abort any transaction when reset is applied mid-transfer, with no further bytes sent.

Configuration
REQ-023 SHALL, with UART_HOST_TIMEOUT_EN defined, count cycles without an rx byte in RECV_DATA/RECV_ACK; on reaching TIMEOUT_CYC it SHALL set err_o, pulse done_o and go to IDLE.
REQ-024 SHALL, with UART_HOST_TIMEOUT_EN undefined, wait indefinitely and include no timeout counter logic.

Structure
REQ-025 SHALL place the opcode constants, the state enum and the STATUS_OK constant in shared package uart_host_pkg.
REQ-026 SHALL implement the 4-byte serializer/deserializer as sub-module uart_host_word with load, shift and pack controls.

Verification
REQ-027 Bench SHALL check: op 0x01, addr 0x0000_0010, len 1, word 0xDEADBEEF -> tx bytes 01 10 00 00 00 01 00 00 00 EF BE AD DE, then rx 0x00 -> done_o pulse, err_o=0.
REQ-028 Bench SHALL check: op 0x04, len 2, rx 11 22 33 44 55 66 77 88 00 -> rd_data_o 0x44332211 then 0x88776655, done_o pulse.
REQ-029 Bench SHALL check: op 0x05 -> single tx byte 05 with tx rdy toggling every other cycle, then done_o pulse and busy_o low.
REQ-030 Bench SHALL check: op 0x02, len 1, rx status 0x01 -> err_o=1; next accepted command -> err_o=0.
REQ-031 Bench SHALL check: reset asserted after 3rd payload byte -> next cycle all outputs at reset values, tx vld 0.
REQ-032 Bench SHALL check, with UART_HOST_TIMEOUT_EN and TIMEOUT_CYC=100, op 0x02 with rx silent -> err_o and done_o at cycle 100 of the wait.
